// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator for the ram512x8 port; turns one load/store request into a RAM transaction.
// Latency: DONE 3+ cycles after accept for a good transfer, 1 cycle for a rejected one, 18 on timeout (default).
// Backpressure: REQ is taken only while BUSY=0; requests while busy (including the DONE cycle) are dropped.
// Optional: define MEM_ALIGN_CHECK_EN to reject unaligned halfword/word requests like an illegal SIZE.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MEM_BYTES      = 512
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        REQ,
   input  logic        RW,
   input  logic [1:0]  SIZE,
   input  logic        SIGNED,
   input  logic [8:0]  ADDR,
   input  logic [31:0] WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic        MEM_EN,
   output logic        MEM_RW,
   output logic [8:0]  MEM_ADDR,
   output logic [31:0] MEM_DIN,
   output logic [1:0]  MEM_MAS,
   input  logic [31:0] MEM_DOUT,
   input  logic        MEM_DONE
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           sgn, sgn_nxt;
   logic           busy_nxt, done_nxt, err_nxt;
   logic [31:0]    rdata_nxt;
   logic           en_nxt, rw_nxt;
   logic [8:0]     addr_nxt;
   logic [31:0]    din_nxt;
   logic [1:0]     mas_nxt;
   logic [10:0]    last_byte;
   logic           req_ok;
   logic [31:0]    load_ext;

   // Request legality: legal size, last byte inside the RAM (10+ bit arithmetic, no wrap), optional alignment
   always_comb begin
      last_byte = {2'b00, ADDR} + ((SIZE == 2'b00) ? 11'd0 : (SIZE == 2'b01) ? 11'd1 : 11'd3);
      req_ok    = (SIZE != 2'b11) && (last_byte < 11'(MEM_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
      if ((SIZE == 2'b01 && ADDR[0]) || (SIZE == 2'b10 && ADDR[1:0] != 2'b00))
         req_ok = 1'b0;
`endif
   end

   // Load data extension, driven by the captured size and signedness of the transfer in flight
   always_comb begin
      case (MEM_MAS)
         2'b00:   load_ext = {{24{sgn & MEM_DOUT[7]}}, MEM_DOUT[7:0]};
         2'b01:   load_ext = {{16{sgn & MEM_DOUT[15]}}, MEM_DOUT[15:0]};
         default: load_ext = MEM_DOUT;
      endcase
   end

   // Next-state and next-output logic; every output is registered from these values
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sgn_nxt   = sgn;
      busy_nxt  = BUSY;
      done_nxt  = 1'b0;
      err_nxt   = ERR;
      rdata_nxt = RDATA;
      en_nxt    = MEM_EN;
      rw_nxt    = MEM_RW;
      addr_nxt  = MEM_ADDR;
      din_nxt   = MEM_DIN;
      mas_nxt   = MEM_MAS;
      case (state)
         ST_IDLE: begin
            if (REQ) begin
               busy_nxt = 1'b1;
               sgn_nxt  = SIGNED;
               if (req_ok) begin
                  // RAM pins are loaded here so they are stable for the whole ISSUE cycle
                  state_nxt = ST_ISSUE;
                  en_nxt    = 1'b1;
                  rw_nxt    = RW;
                  addr_nxt  = ADDR;
                  din_nxt   = WDATA;
                  mas_nxt   = SIZE;
               end else begin
                  state_nxt = ST_RESP;
                  done_nxt  = 1'b1;
                  err_nxt   = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (MEM_DONE) begin
               if (MEM_RW)
                  rdata_nxt = load_ext;
               en_nxt    = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = ST_RESP;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               en_nxt    = 1'b0;
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = ST_RESP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_RESP: begin
            busy_nxt  = 1'b0;
            err_nxt   = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and output registers; CLR overrides everything and silently abandons any transfer
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sgn      <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         RDATA    <= '0;
         MEM_EN   <= 1'b0;
         MEM_RW   <= 1'b0;
         MEM_ADDR <= '0;
         MEM_DIN  <= '0;
         MEM_MAS  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sgn      <= sgn_nxt;
         BUSY     <= busy_nxt;
         DONE     <= done_nxt;
         ERR      <= err_nxt;
         RDATA    <= rdata_nxt;
         MEM_EN   <= en_nxt;
         MEM_RW   <= rw_nxt;
         MEM_ADDR <= addr_nxt;
         MEM_DIN  <= din_nxt;
         MEM_MAS  <= mas_nxt;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus random load/store traffic against a byte-array RAM model.
// Expected timing, error and load results come from a request-level reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mem_access_ctrl;

   localparam int TO   = 16;
   localparam int MEMB = 512;

   logic        CLK = 1'b0;
   logic        CLR = 1'b1;
   logic        REQ = 1'b0;
   logic        RW = 1'b0;
   logic [1:0]  SIZE = 2'b00;
   logic        SIGNED = 1'b0;
   logic [8:0]  ADDR = '0;
   logic [31:0] WDATA = '0;
   logic        BUSY, DONE, ERR, MEM_EN, MEM_RW;
   logic [31:0] RDATA, MEM_DIN;
   logic [8:0]  MEM_ADDR;
   logic [1:0]  MEM_MAS;
   logic [31:0] MEM_DOUT = '0;
   logic        MEM_DONE = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [7:0]  ram_mem [0:MEMB-1];
   logic [7:0]  ref_mem [0:MEMB-1];
   logic [31:0] exp_rdata = '0;
   int          ram_lat = 1;
   int          ram_cnt = 0;
   int          ra;
   logic [31:0] rd;

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .MEM_BYTES(MEMB)) dut (
      .CLK(CLK), .CLR(CLR), .REQ(REQ), .RW(RW), .SIZE(SIZE), .SIGNED(SIGNED),
      .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
      .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
      .MEM_MAS(MEM_MAS), .MEM_DOUT(MEM_DOUT), .MEM_DONE(MEM_DONE)
   );

   always #5 CLK = ~CLK;

   // RAM model: raises done ram_lat falling edges after EN rises (0 = never), holds it while EN stays high
   always @(negedge CLK) begin
      if (MEM_EN) begin
         ram_cnt = ram_cnt + 1;
         if (ram_lat != 0 && ram_cnt == ram_lat) begin
            MEM_DONE = 1'b1;
            ra = int'(MEM_ADDR);
            if (MEM_RW) begin
               rd = $urandom;
               case (MEM_MAS)
                  2'b00:   rd[7:0]  = ram_mem[ra];
                  2'b01:   rd[15:0] = {ram_mem[ra], ram_mem[ra+1]};
                  default: rd       = {ram_mem[ra], ram_mem[ra+1], ram_mem[ra+2], ram_mem[ra+3]};
               endcase
               MEM_DOUT = rd;
            end else begin
               case (MEM_MAS)
                  2'b00: ram_mem[ra] = MEM_DIN[7:0];
                  2'b01: begin ram_mem[ra] = MEM_DIN[15:8]; ram_mem[ra+1] = MEM_DIN[7:0]; end
                  default: begin
                     ram_mem[ra]   = MEM_DIN[31:24];
                     ram_mem[ra+1] = MEM_DIN[23:16];
                     ram_mem[ra+2] = MEM_DIN[15:8];
                     ram_mem[ra+3] = MEM_DIN[7:0];
                  end
               endcase
            end
         end
      end else begin
         ram_cnt  = 0;
         MEM_DONE = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference load: numeric value of the big-endian bytes, optionally reinterpreted as two's complement
   function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input bit sg);
      longint v;
      if (sz == 2'b00) begin
         v = longint'(ref_mem[a]);
         if (sg && v >= 128) v = v - 256;
      end else if (sz == 2'b01) begin
         v = longint'(ref_mem[a]) * 256 + longint'(ref_mem[a+1]);
         if (sg && v >= 32768) v = v - 65536;
      end else begin
         v = ((longint'(ref_mem[a]) * 256 + longint'(ref_mem[a+1])) * 256
              + longint'(ref_mem[a+2])) * 256 + longint'(ref_mem[a+3]);
      end
      return v[31:0];
   endfunction

   // One transfer from request to the idle cycle after DONE; poke keeps REQ high through RESP
   task automatic xfer(input bit rw, input logic [1:0] sz, input bit sg, input logic [8:0] a,
                       input logic [31:0] wd, input int lat, input bit poke);
      int  nb, exp_cyc, en_cnt, done_cyc, unstable;
      bit  legal, exp_err;
      nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      legal = (sz != 2'b11) && (int'(a) + nb - 1 < MEMB);
`ifdef MEM_ALIGN_CHECK_EN
      if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) legal = 1'b0;
`endif
      if (!legal) begin exp_cyc = 1; exp_err = 1'b1; end
      else if (lat == 0) begin exp_cyc = TO + 2; exp_err = 1'b1; end
      else begin exp_cyc = ((lat > 2) ? lat : 2) + 1; exp_err = 1'b0; end
      if (legal && lat != 0) begin
         if (rw) exp_rdata = ref_load(int'(a), sz, sg);
         else for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * (nb - 1 - i)));
      end
      ram_lat = lat;
      REQ = 1'b1; RW = rw; SIZE = sz; SIGNED = sg; ADDR = a; WDATA = wd;
      @(posedge CLK);
      en_cnt = 0; done_cyc = 0; unstable = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge CLK);
         if (cyc == 1 && !poke) REQ = 1'b0;
         if (MEM_EN) begin
            en_cnt++;
            if (MEM_ADDR !== a || MEM_MAS !== sz || MEM_RW !== rw || MEM_DIN !== wd) unstable++;
         end
         if (cyc == 1) check("busy_after_accept", 32'(BUSY), 32'd1);
         if (DONE === 1'b1) begin
            done_cyc = cyc;
            check("err_with_done", 32'(ERR), 32'(exp_err));
            check("rdata", RDATA, exp_rdata);
            break;
         end
      end
      if (done_cyc == 0) check("done_never_seen", 32'd0, 32'd1);
      check("done_cycle", 32'(done_cyc), 32'(exp_cyc));
      check("mem_en_cycles", 32'(en_cnt), legal ? 32'(exp_cyc - 1) : 32'd0);
      check("mem_pins_stable", 32'(unstable), 32'd0);
      @(negedge CLK);
      REQ = 1'b0;
      check("busy_cleared", 32'(BUSY), 32'd0);
      check("done_single", 32'(DONE), 32'd0);
      check("err_cleared", 32'(ERR), 32'd0);
      check("mem_en_idle", 32'(MEM_EN), 32'd0);
   endtask

   bit          r_rw, r_sg;
   logic [1:0]  r_sz;
   logic [8:0]  r_a;
   int          r_lat, ndone;

   initial begin
      for (int i = 0; i < MEMB; i++) begin
         ram_mem[i] = 8'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      // reset state
      repeat (3) @(negedge CLK);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_mem_en", 32'(MEM_EN), 32'd0);
      check("rst_mem_rw", 32'(MEM_RW), 32'd0);
      check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
      check("rst_mem_din", MEM_DIN, 32'd0);
      check("rst_mem_mas", 32'(MEM_MAS), 32'd0);
      CLR = 1'b0;
      @(negedge CLK);

      // word store then load
      xfer(1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1, 1'b0);
      xfer(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 1, 1'b0);
      check("word_load", RDATA, 32'hDEADBEEF);
      // byte 0x80 signed / unsigned, halfword 0x8001 signed
      xfer(1'b0, 2'b00, 1'b0, 9'h013, 32'h12345680, 2, 1'b0);
      xfer(1'b1, 2'b00, 1'b1, 9'h013, 32'h0, 1, 1'b0);
      check("byte_signed", RDATA, 32'hFFFFFF80);
      xfer(1'b1, 2'b00, 1'b0, 9'h013, 32'h0, 3, 1'b0);
      check("byte_unsigned", RDATA, 32'h00000080);
      xfer(1'b0, 2'b01, 1'b0, 9'h020, 32'hCAFE8001, 1, 1'b0);
      xfer(1'b1, 2'b01, 1'b1, 9'h020, 32'h0, 1, 1'b0);
      check("half_signed", RDATA, 32'hFFFF8001);
      // rejects and the top-of-memory boundary
      xfer(1'b1, 2'b01, 1'b0, 9'h1FF, 32'h0, 1, 1'b0);
      xfer(1'b1, 2'b10, 1'b0, 9'h1FF, 32'h0, 1, 1'b0);
      xfer(1'b1, 2'b10, 1'b0, 9'h1FC, 32'h0, 2, 1'b0);
      xfer(1'b0, 2'b11, 1'b0, 9'h000, 32'h55AA55AA, 1, 1'b0);
      // timeout leaves RDATA alone
      xfer(1'b1, 2'b10, 1'b0, 9'h040, 32'h0, 0, 1'b0);
      // REQ held through WAIT and RESP produces one DONE only
      xfer(1'b1, 2'b00, 1'b1, 9'h013, 32'h0, 4, 1'b1);
      ndone = 0;
      repeat (6) begin @(negedge CLK); if (DONE === 1'b1) ndone++; end
      check("no_extra_done", 32'(ndone), 32'd0);
      // unaligned word: rejected or passed through depending on build
      xfer(1'b1, 2'b10, 1'b0, 9'h011, 32'h0, 1, 1'b0);

      // CLR during WAIT: transfer abandoned, no DONE ever
      ram_lat = 0;
      REQ = 1'b1; RW = 1'b1; SIZE = 2'b10; SIGNED = 1'b0; ADDR = 9'h030;
      @(posedge CLK);
      @(negedge CLK); REQ = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("pre_clr_busy", 32'(BUSY), 32'd1);
      check("pre_clr_mem_en", 32'(MEM_EN), 32'd1);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      exp_rdata = '0;
      check("clr_mem_en", 32'(MEM_EN), 32'd0);
      check("clr_busy", 32'(BUSY), 32'd0);
      check("clr_rdata", RDATA, 32'd0);
      ndone = 0;
      repeat (25) begin @(negedge CLK); if (DONE === 1'b1) ndone++; end
      check("clr_no_done", 32'(ndone), 32'd0);

      // random traffic, biased toward the top of memory and short RAM latencies
      for (int i = 0; i < 60; i++) begin
         r_rw  = 1'($urandom);
         r_sg  = 1'($urandom);
         r_sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_a   = ($urandom_range(0, 3) == 0) ? 9'(508 + $urandom_range(0, 3)) : 9'($urandom_range(0, 511));
         r_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
         xfer(r_rw, r_sz, r_sg, r_a, $urandom, r_lat, 1'($urandom_range(0, 5) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
